// File: rtl/video_types_pkg.sv
// Shared LCD timing types: PPU mode encoding, default frame geometry, STAT source selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   lcd_mode_e      PPU mode as seen on the STAT register (HBLANK=0 VBLANK=1 OAM_SCAN=2 XFER=3)
//   LCD_* params    default dot/line geometry of one frame
//   stat_sel_t      STAT interrupt source enables {lyc, oam, vblank, hblank}
package video_types;

    typedef enum logic [1:0] {
        LCD_HBLANK   = 2'd0,
        LCD_VBLANK   = 2'd1,
        LCD_OAM_SCAN = 2'd2,
        LCD_XFER     = 2'd3
    } lcd_mode_e;

    localparam int LCD_DOTS_PER_LINE = 456;
    localparam int LCD_OAM_DOTS      = 80;
    localparam int LCD_XFER_DOTS     = 172;
    localparam int LCD_VISIBLE_LINES = 144;
    localparam int LCD_TOTAL_LINES   = 154;

    typedef struct packed {
        logic lyc;
        logic oam;
        logic vblank;
        logic hblank;
    } stat_sel_t;

    // OAM is owned by the PPU while it scans sprites and while it pushes pixels.
    function automatic logic mode_owns_oam(lcd_mode_e m);
        return (m == LCD_OAM_SCAN) || (m == LCD_XFER);
    endfunction

endpackage

// File: rtl/lcd_stat_irq_gen.sv
// STAT interrupt generator: ORs the enabled mode/LYC sources and pulses on the rising edge.
// Latency: outputs registered, one edge after the next-state mode/line presented by the sequencer.
// Backpressure: none; free-running pulse outputs, no handshake.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   enable_i          LCD enable; while low the condition history is cleared and no pulse issues
//   mode_nxt_i        mode the sequencer registers on this edge
//   ly_nxt_i          line the sequencer registers on this edge
//   lyc_i, stat_sel_i LY compare value and STAT source enables, sampled every cycle
//   stat_irq_o        one-cycle pulse on a rising STAT condition
//   lyc_match_o       registered ly==lyc
// Optional feature: LCD_LYC_IRQ_EN builds the LY compare; without it lyc_match_o is 0
// and the lyc source enable is ignored.
module lcd_stat_irq_gen
    import video_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  lcd_mode_e  mode_nxt_i,
    input  logic [7:0] ly_nxt_i,
    input  logic [7:0] lyc_i,
    input  logic [3:0] stat_sel_i,
    output logic       stat_irq_o,
    output logic       lyc_match_o
);

    stat_sel_t sel;
    logic      lyc_match_d;
    logic      lyc_term;
    logic      cond_d;
    logic      cond_q;
    logic      stat_irq_q;
    logic      lyc_match_q;

    assign sel = stat_sel_i;

`ifdef LCD_LYC_IRQ_EN
    // Compared against the line being entered so the match lines up with ly.
    assign lyc_match_d = (ly_nxt_i == lyc_i);
    assign lyc_term    = sel.lyc & lyc_match_d;
`else
    logic lyc_path_unused;
    assign lyc_path_unused = sel.lyc ^ (^lyc_i) ^ (^ly_nxt_i);
    assign lyc_match_d     = 1'b0;
    assign lyc_term        = 1'b0;
`endif

    assign cond_d = (sel.hblank & (mode_nxt_i == LCD_HBLANK))
                  | (sel.vblank & (mode_nxt_i == LCD_VBLANK))
                  | (sel.oam    & (mode_nxt_i == LCD_OAM_SCAN))
                  | lyc_term;

    // Edge detect gives STAT blocking: a condition that stays high across a
    // mode change (e.g. HBLANK straight into VBLANK) produces no second pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q      <= 1'b0;
            stat_irq_q  <= 1'b0;
            lyc_match_q <= 1'b0;
        end else begin
            cond_q      <= enable_i & cond_d;
            stat_irq_q  <= enable_i & cond_d & ~cond_q;
            lyc_match_q <= lyc_match_d;
        end
    end

    assign stat_irq_o  = stat_irq_q;
    assign lyc_match_o = lyc_match_q;

endmodule

// File: rtl/lcd_mode_sequencer.sv
// LCD timing master: dot/line counters, PPU mode FSM, drawline strobe, vblank/STAT irqs, CPU access gates.
// Latency: every output is registered and reflects the dot/line position reached on that edge.
// Backpressure: none; the renderer must accept the one-cycle drawline strobe when it fires.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   lcd_enable           LCDC enable level; low holds position at line 0 dot 0 in HBLANK
//   stat_sel, lyc        STAT source enables {lyc,oam,vblank,hblank} and LY compare value
//   mode, ly             current PPU mode and line
//   drawline             one-cycle pulse on XFER entry: render line ly
//   render_complete      high throughout VBLANK
//   vblank_irq, stat_irq one-cycle interrupt pulses
//   lyc_match            ly==lyc (only with LCD_LYC_IRQ_EN, otherwise 0)
//   vram_cpu_ok          low in XFER
//   oam_cpu_ok           low in OAM_SCAN and XFER
// Optional feature: LCD_LYC_IRQ_EN enables the LY compare and its STAT source.
module lcd_mode_sequencer
    import video_types::*;
#(
    parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
    parameter int OAM_DOTS      = LCD_OAM_DOTS,
    parameter int XFER_DOTS     = LCD_XFER_DOTS,
    parameter int VISIBLE_LINES = LCD_VISIBLE_LINES,
    parameter int TOTAL_LINES   = LCD_TOTAL_LINES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_enable,
    input  logic [3:0] stat_sel,
    input  logic [7:0] lyc,
    output logic [1:0] mode,
    output logic [7:0] ly,
    output logic       drawline,
    output logic       render_complete,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       lyc_match,
    output logic       vram_cpu_ok,
    output logic       oam_cpu_ok
);

    localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_XFER = 9'(OAM_DOTS);
    localparam logic [8:0] DOT_HBL  = 9'(OAM_DOTS + XFER_DOTS);
    localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LY_VBL   = 8'(VISIBLE_LINES);

    logic       en_q;
    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d;
    lcd_mode_e  mode_q, mode_d;
    logic       drawline_q;
    logic       vblank_irq_q;
    logic       render_complete_q;
    logic       vram_ok_q;
    logic       oam_ok_q;
    logic       running;
    logic       last_dot;

    // running: enabled now and on the previous edge; the first enabled edge
    // only establishes line 0 dot 0 in OAM_SCAN.
    assign running  = lcd_enable & en_q;
    assign last_dot = (dot_q == DOT_LAST);

    always_comb begin
        dot_d  = 9'd0;
        ly_d   = 8'd0;
        mode_d = LCD_HBLANK;
        if (lcd_enable && !en_q) begin
            mode_d = LCD_OAM_SCAN;
        end else if (running) begin
            dot_d  = last_dot ? 9'd0 : dot_q + 9'd1;
            ly_d   = !last_dot ? ly_q : ((ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1);
            mode_d = mode_q;
            unique case (mode_q)
                LCD_OAM_SCAN: if (dot_d == DOT_XFER) mode_d = LCD_XFER;
                LCD_XFER:     if (dot_d == DOT_HBL)  mode_d = LCD_HBLANK;
                LCD_HBLANK:   if (last_dot)          mode_d = (ly_d == LY_VBL) ? LCD_VBLANK : LCD_OAM_SCAN;
                LCD_VBLANK:   if (last_dot && ly_q == LY_LAST) mode_d = LCD_OAM_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q              <= 1'b0;
            dot_q             <= 9'd0;
            ly_q              <= 8'd0;
            mode_q            <= LCD_HBLANK;
            drawline_q        <= 1'b0;
            vblank_irq_q      <= 1'b0;
            render_complete_q <= 1'b0;
            vram_ok_q         <= 1'b1;
            oam_ok_q          <= 1'b1;
        end else begin
            en_q              <= lcd_enable;
            dot_q             <= dot_d;
            ly_q              <= ly_d;
            mode_q            <= mode_d;
            drawline_q        <= running && (mode_q == LCD_OAM_SCAN) && (mode_d == LCD_XFER);
            vblank_irq_q      <= running && (mode_q != LCD_VBLANK) && (mode_d == LCD_VBLANK);
            render_complete_q <= (mode_d == LCD_VBLANK);
            vram_ok_q         <= (mode_d != LCD_XFER);
            oam_ok_q          <= !mode_owns_oam(mode_d);
        end
    end

    lcd_stat_irq_gen u_stat (
        .clk        (clk),
        .reset      (reset),
        .enable_i   (lcd_enable),
        .mode_nxt_i (mode_d),
        .ly_nxt_i   (ly_d),
        .lyc_i      (lyc),
        .stat_sel_i (stat_sel),
        .stat_irq_o (stat_irq),
        .lyc_match_o(lyc_match)
    );

    assign mode            = mode_q;
    assign ly              = ly_q;
    assign drawline        = drawline_q;
    assign render_complete = render_complete_q;
    assign vblank_irq      = vblank_irq_q;
    assign vram_cpu_ok     = vram_ok_q;
    assign oam_cpu_ok      = oam_ok_q;

endmodule

// File: tb/tb_lcd_mode_sequencer.sv
// Testbench for lcd_mode_sequencer: random STAT/LYC stimulus against a position-based frame model.
// Latency: expectations are queued per edge and popped by a monitor 1 ns after each rising edge.
// Backpressure: n/a.
module tb_lcd_mode_sequencer;

    localparam int DPL    = 456;
    localparam int FRAME  = 456 * 154;
`ifdef LCD_LYC_IRQ_EN
    localparam bit LYC_ON = 1'b1;
`else
    localparam bit LYC_ON = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] ly;
        logic       drawline;
        logic       render_complete;
        logic       vblank_irq;
        logic       stat_irq;
        logic       lyc_match;
        logic       vram_cpu_ok;
        logic       oam_cpu_ok;
    } obs_t;

    logic       clk;
    logic       reset;
    logic       lcd_enable;
    logic [3:0] stat_sel;
    logic [7:0] lyc;
    logic [1:0] mode;
    logic [7:0] ly;
    logic       drawline, render_complete, vblank_irq, stat_irq, lyc_match, vram_cpu_ok, oam_cpu_ok;

    lcd_mode_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .lcd_enable     (lcd_enable),
        .stat_sel       (stat_sel),
        .lyc            (lyc),
        .mode           (mode),
        .ly             (ly),
        .drawline       (drawline),
        .render_complete(render_complete),
        .vblank_irq     (vblank_irq),
        .stat_irq       (stat_irq),
        .lyc_match      (lyc_match),
        .vram_cpu_ok    (vram_cpu_ok),
        .oam_cpu_ok     (oam_cpu_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    // Reference model state: edges since the first enabled edge, frame-relative.
    bit   m_run = 1'b0;
    int   m_t = 0;
    bit   m_cond_prev = 1'b0;

    bit   count_en = 1'b0, win_a = 1'b0, win_b = 1'b0, win_c = 1'b0;
    int   n_draw = 0, n_vbl = 0, n_sa = 0, n_sb = 0, n_sc = 0;

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.vram_cpu_ok = 1'b1;
        o.oam_cpu_ok  = 1'b1;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.mode = mode; o.ly = ly; o.drawline = drawline; o.render_complete = render_complete;
        o.vblank_irq = vblank_irq; o.stat_irq = stat_irq; o.lyc_match = lyc_match;
        o.vram_cpu_ok = vram_cpu_ok; o.oam_cpu_ok = oam_cpu_ok;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got mode=%0d ly=%0d dl=%b rc=%b vbl=%b stat=%b lm=%b vram=%b oam=%b, want mode=%0d ly=%0d dl=%b rc=%b vbl=%b stat=%b lm=%b vram=%b oam=%b",
                     name, $time, got.mode, got.ly, got.drawline, got.render_complete, got.vblank_irq,
                     got.stat_irq, got.lyc_match, got.vram_cpu_ok, got.oam_cpu_ok,
                     want.mode, want.ly, want.drawline, want.render_complete, want.vblank_irq,
                     want.stat_irq, want.lyc_match, want.vram_cpu_ok, want.oam_cpu_ok);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Expected outputs after the coming edge, derived from the frame position.
    task automatic model_step();
        obs_t e;
        int   dot, line;
        bit   cond;
        e = reset_obs();
        if (reset) begin
            m_run = 1'b0;
            m_cond_prev = 1'b0;
        end else if (!lcd_enable) begin
            m_run = 1'b0;
            m_cond_prev = 1'b0;
            e.lyc_match = LYC_ON && (lyc == 8'd0);
        end else begin
            if (!m_run) begin
                m_t = 0;
                m_run = 1'b1;
            end else begin
                m_t = (m_t + 1) % FRAME;
            end
            dot  = m_t % DPL;
            line = m_t / DPL;
            if (line >= 144)    e.mode = 2'd1;
            else if (dot < 80)  e.mode = 2'd2;
            else if (dot < 252) e.mode = 2'd3;
            else                e.mode = 2'd0;
            e.ly              = 8'(line);
            e.drawline        = (line < 144) && (dot == 80);
            e.vblank_irq      = (line == 144) && (dot == 0);
            e.render_complete = (e.mode == 2'd1);
            e.vram_cpu_ok     = (e.mode != 2'd3);
            e.oam_cpu_ok      = (e.mode < 2'd2);
            e.lyc_match       = LYC_ON && (line == int'(lyc));
            cond = (stat_sel[0] && e.mode == 2'd0) || (stat_sel[1] && e.mode == 2'd1) ||
                   (stat_sel[2] && e.mode == 2'd2) || (LYC_ON && stat_sel[3] && e.lyc_match);
            e.stat_irq  = cond && !m_cond_prev;
            m_cond_prev = cond;
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 199) == 0) stat_sel = 4'($urandom);
            if ($urandom_range(0, 499) == 0) lyc = 8'($urandom_range(0, 160));
            model_step();
            @(negedge clk);
        end
    endtask

    // Monitor: one expectation per rising edge once stimulus has started.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_obs("cycle", dut_obs(), e);
            end
            if (count_en) begin
                n_draw += int'(drawline);
                n_vbl  += int'(vblank_irq);
            end
            if (win_a) n_sa += int'(stat_irq);
            if (win_b) n_sb += int'(stat_irq);
            if (win_c) n_sc += int'(stat_irq);
        end
    end

    initial begin
        int line;
        int drop_line;
        reset = 1'b1; lcd_enable = 1'b0; stat_sel = 4'd0; lyc = 8'd0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin model_step(); @(negedge clk); end

        // Released but disabled: position held, lyc=0 matches line 0.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin model_step(); @(negedge clk); end

        // One full frame from the first enabled edge; i is the position reached.
        lcd_enable = 1'b1;
        count_en = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            line = i / DPL;
            if (line >= 140 && line <= 146) stat_sel = 4'b0011;
            else if (line >= 8 && line <= 12) begin stat_sel = 4'b1000; lyc = 8'd10; end
            else if (line < 4) stat_sel = 4'b0001;
            else if ($urandom_range(0, 199) == 0) stat_sel = 4'($urandom);
            if (!(line >= 8 && line <= 12) && $urandom_range(0, 999) == 0) lyc = 8'($urandom_range(0, 160));
            win_a = (i < 4 * DPL);
            win_b = (i >= 143 * DPL + 300) && (i < 147 * DPL);
            win_c = (i >= 8 * DPL) && (i < 13 * DPL);
            model_step();
            @(negedge clk);
        end
        count_en = 1'b0; win_a = 1'b0; win_b = 1'b0; win_c = 1'b0;
        check_int("drawline_per_frame", n_draw, 144);
        check_int("vblank_irq_per_frame", n_vbl, 1);
        check_int("stat_hblank_lines0_3", n_sa, 4);
        check_int("stat_blocked_vblank_entry", n_sb, 0);
        check_int("stat_lyc_line10", n_sc, LYC_ON ? 1 : 0);

        // Continue into frame 2 up to line 20 dot 150 (XFER), then reset asynchronously.
        stat_sel = 4'b0001;
        run(20 * DPL + 151);
        reset = 1'b1;
        #1;
        check_obs("async_reset_in_xfer", dut_obs(), reset_obs());
        for (int i = 0; i < 2; i++) begin model_step(); @(negedge clk); end

        // Restart, drop enable mid-line at dot 100 of a random line, then re-enable.
        reset = 1'b0;
        drop_line = $urandom_range(3, 15);
        run(drop_line * DPL + 101);
        lcd_enable = 1'b0;
        run(3);
        lcd_enable = 1'b1;
        run(600);

        @(posedge clk);
        #2;
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
